// File: rtl/ahb_slave_arbiter_pkg.sv
// ahb_slave_arbiter_pkg: AHB transfer/burst encodings and arbitration constants
package ahb_slave_arbiter_pkg;
  typedef enum logic [1:0] {TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11} htrans_t;
  typedef enum logic [2:0] {
    HB_SINGLE = 3'd0, HB_INCR = 3'd1, HB_WRAP4 = 3'd2, HB_INCR4 = 3'd3,
    HB_WRAP8 = 3'd4, HB_INCR8 = 3'd5, HB_WRAP16 = 3'd6, HB_INCR16 = 3'd7
  } hburst_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_OWNED = 1'b1} arb_state_t;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR = 1;
  function automatic logic [4:0] burst_beats(input hburst_t b);
    return (b inside {HB_INCR4, HB_WRAP4}) ? 5'd4 :
           (b inside {HB_INCR8, HB_WRAP8}) ? 5'd8 :
           (b inside {HB_INCR16, HB_WRAP16}) ? 5'd16 : 5'd1;
  endfunction
endpackage

// File: rtl/ahb_slave_arbiter_picker.sv
// ahb_arb_picker: combinational winner select, fixed priority or rotating start point
module ahb_arb_picker #(
  parameter int MASTER_NUM = 2,
  parameter int MW = $clog2(MASTER_NUM)
) (
  input  logic [MASTER_NUM-1:0] req,
  input  logic [MW-1:0]         ptr,
  input  logic                  rr,
  output logic [MASTER_NUM-1:0] grant,
  output logic [MW-1:0]         idx,
  output logic                  any
);
  function automatic logic [MW-1:0] wrap(input int v);
    return MW'(v >= MASTER_NUM ? v - MASTER_NUM : v);
  endfunction
  // scan from the furthest offset back to the start so the nearest requester wins
  always_comb begin
    idx = '0;
    for (int i = MASTER_NUM - 1; i >= 0; i--)
      if (req[wrap((rr ? int'(ptr) : 0) + i)]) idx = wrap((rr ? int'(ptr) : 0) + i);
  end
  assign any = |req;
  assign grant = any ? (MASTER_NUM'(1) << idx) : '0;
endmodule

// File: rtl/ahb_slave_arbiter.sv
// ahb_slave_arbiter: per-slave owner sequencing with burst/lock/INCR hold and fixed or round-robin pick
module ahb_slave_arbiter
  import ahb_slave_arbiter_pkg::*;
#(
  parameter int MASTER_NUM = 2,
  parameter int ARB_MODE = ARB_RR,
  parameter int MW = $clog2(MASTER_NUM)
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [MASTER_NUM-1:0]      hreq_i,
  input  logic [MASTER_NUM-1:0][1:0] htrans_i,
  input  logic [MASTER_NUM-1:0][2:0] hburst_i,
  input  logic [MASTER_NUM-1:0]      hmastlock_i,
  input  logic                       hready_i,
  output logic [MASTER_NUM-1:0]      addr_sel_o,
  output logic [MASTER_NUM-1:0]      data_sel_o,
  output logic [MW-1:0]              hmaster_o,
  output logic                       owner_valid_o
);
  arb_state_t state;
  logic [3:0] beat_cnt, beat_nxt;
  logic [MW-1:0] rr_ptr, win_idx;
  logic [MASTER_NUM-1:0] win_grant;
  logic win_any, own_act, own_req, hold;
  htrans_t own_trans;
  hburst_t own_burst;
  assign own_trans = htrans_t'(htrans_i[hmaster_o]);
  assign own_burst = hburst_t'(hburst_i[hmaster_o]);
  assign own_req = hreq_i[hmaster_o];
  assign own_act = own_trans inside {TR_NONSEQ, TR_SEQ};
  assign beat_nxt = own_trans == TR_NONSEQ ? 4'(burst_beats(own_burst) - 5'd1) :
                    (own_trans == TR_SEQ && beat_cnt != 4'd0) ? beat_cnt - 4'd1 : beat_cnt;
  assign hold = state == ST_OWNED &&
                ((beat_nxt != 4'd0 && own_req) || hmastlock_i[hmaster_o] || own_trans == TR_BUSY ||
                 (own_act && own_burst == HB_INCR && own_req));
  ahb_arb_picker #(.MASTER_NUM(MASTER_NUM), .MW(MW)) u_picker (
    .req  (hreq_i),
    .ptr  (rr_ptr),
    .rr   (ARB_MODE == ARB_RR),
    .grant(win_grant),
    .idx  (win_idx),
    .any  (win_any)
  );
  // ownership FSM: everything advances only on accepting edges
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
      beat_cnt <= '0;
      rr_ptr <= '0;
      addr_sel_o <= '0;
      data_sel_o <= '0;
      hmaster_o <= '0;
      owner_valid_o <= 1'b0;
    end else if (hready_i) begin
      data_sel_o <= (state == ST_OWNED && own_act) ? addr_sel_o : '0;
      if (hold) begin
        beat_cnt <= beat_nxt;
      end else begin
        beat_cnt <= '0;
        state <= win_any ? ST_OWNED : ST_IDLE;
        addr_sel_o <= win_grant;
        owner_valid_o <= win_any;
        if (win_any) begin
          hmaster_o <= win_idx;
          rr_ptr <= win_idx == MW'(MASTER_NUM - 1) ? '0 : win_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// tb_ahb_slave_arbiter: vector table with scoreboard for round-robin and fixed-priority instances
module tb_ahb_slave_arbiter;
  localparam int M = 3;
  localparam logic [1:0] I = 2'd0, B = 2'd1, N = 2'd2, S = 2'd3;
  localparam logic [2:0] SG = 3'd0, IC = 3'd1, I4 = 3'd3, I8 = 3'd5;
  typedef struct packed {
    logic [2:0] req;
    logic [5:0] tr;
    logic [8:0] bu;
    logic [2:0] lk;
    logic       rdy;
    logic [2:0] ea;
    logic [2:0] ed;
    logic [1:0] em;
    logic       ev;
    logic       fx;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1;
  logic [M-1:0] req = '0, lk = '0;
  logic [M-1:0][1:0] tr = '0;
  logic [M-1:0][2:0] bu = '0;
  logic [M-1:0] ra, rd, fa, fd;
  logic [1:0] rm, fm;
  logic rv, fv;
  int checks = 0, errors = 0, vn = 0;
  vec_t tbl[$];
  vec_t sb[$];
  always #5 clk = ~clk;
  ahb_slave_arbiter #(.MASTER_NUM(M), .ARB_MODE(1)) dut_rr (
    .HCLK(clk), .HRESETn(rst_n), .hreq_i(req), .htrans_i(tr), .hburst_i(bu),
    .hmastlock_i(lk), .hready_i(rdy), .addr_sel_o(ra), .data_sel_o(rd),
    .hmaster_o(rm), .owner_valid_o(rv)
  );
  ahb_slave_arbiter #(.MASTER_NUM(M), .ARB_MODE(0)) dut_fx (
    .HCLK(clk), .HRESETn(rst_n), .hreq_i(req), .htrans_i(tr), .hburst_i(bu),
    .hmastlock_i(lk), .hready_i(rdy), .addr_sel_o(fa), .data_sel_o(fd),
    .hmaster_o(fm), .owner_valid_o(fv)
  );
  function automatic vec_t vec(input logic [2:0] r, input logic [5:0] t, input logic [8:0] b,
                               input logic [2:0] l, input logic y, input logic [2:0] a,
                               input logic [2:0] d, input logic [1:0] m, input logic v, input logic f);
    vec_t x;
    x.req = r; x.tr = t; x.bu = b; x.lk = l; x.rdy = y;
    x.ea = a; x.ed = d; x.em = m; x.ev = v; x.fx = f;
    return x;
  endfunction
  task automatic chk(input string nm, input int idx, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s vec %0d got %0h want %0h", nm, idx, got, want);
    end
  endtask
  task automatic zero_chk(input string nm);
    chk({nm, " addr_sel rr"}, vn, {1'b0, ra}, 4'd0);
    chk({nm, " data_sel rr"}, vn, {1'b0, rd}, 4'd0);
    chk({nm, " hmaster rr"}, vn, {2'b0, rm}, 4'd0);
    chk({nm, " valid rr"}, vn, {3'b0, rv}, 4'd0);
    chk({nm, " addr_sel fx"}, vn, {1'b0, fa}, 4'd0);
    chk({nm, " data_sel fx"}, vn, {1'b0, fd}, 4'd0);
    chk({nm, " hmaster fx"}, vn, {2'b0, fm}, 4'd0);
    chk({nm, " valid fx"}, vn, {3'b0, fv}, 4'd0);
  endtask
  task automatic apply(input vec_t v);
    vec_t e;
    req = v.req; tr = v.tr; bu = v.bu; lk = v.lk; rdy = v.rdy;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("addr_sel", vn, {1'b0, e.fx ? fa : ra}, {1'b0, e.ea});
    chk("data_sel", vn, {1'b0, e.fx ? fd : rd}, {1'b0, e.ed});
    chk("hmaster", vn, {2'b0, e.fx ? fm : rm}, {2'b0, e.em});
    chk("valid", vn, {3'b0, e.fx ? fv : rv}, {3'b0, e.ev});
    vn++;
  endtask
  task automatic run_tbl();
    foreach (tbl[i]) apply(tbl[i]);
    tbl.delete();
  endtask
  initial begin
    #12;
    zero_chk("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // round robin, all masters issuing SINGLEs
    tbl.push_back(vec(3'b111, {N,N,N}, {SG,SG,SG}, 3'b000, 1, 3'b001, 3'b000, 0, 1, 0));
    tbl.push_back(vec(3'b111, {N,N,N}, {SG,SG,SG}, 3'b000, 1, 3'b010, 3'b001, 1, 1, 0));
    tbl.push_back(vec(3'b111, {N,N,N}, {SG,SG,SG}, 3'b000, 1, 3'b100, 3'b010, 2, 1, 0));
    tbl.push_back(vec(3'b111, {N,N,N}, {SG,SG,SG}, 3'b000, 1, 3'b001, 3'b100, 0, 1, 0));
    tbl.push_back(vec(3'b000, {I,I,I}, {SG,SG,SG}, 3'b000, 1, 3'b000, 3'b000, 0, 0, 0));
    // INCR4 by M0 with M1 waiting and two wait states
    tbl.push_back(vec(3'b001, {I,I,N}, {SG,SG,I4}, 3'b000, 1, 3'b001, 3'b000, 0, 1, 0));
    tbl.push_back(vec(3'b011, {I,N,N}, {SG,SG,I4}, 3'b000, 1, 3'b001, 3'b001, 0, 1, 0));
    tbl.push_back(vec(3'b011, {I,N,S}, {SG,SG,I4}, 3'b000, 0, 3'b001, 3'b001, 0, 1, 0));
    tbl.push_back(vec(3'b011, {I,N,S}, {SG,SG,I4}, 3'b000, 0, 3'b001, 3'b001, 0, 1, 0));
    tbl.push_back(vec(3'b011, {I,N,S}, {SG,SG,I4}, 3'b000, 1, 3'b001, 3'b001, 0, 1, 0));
    tbl.push_back(vec(3'b011, {I,N,S}, {SG,SG,I4}, 3'b000, 1, 3'b001, 3'b001, 0, 1, 0));
    tbl.push_back(vec(3'b011, {I,N,S}, {SG,SG,I4}, 3'b000, 1, 3'b010, 3'b001, 1, 1, 0));
    tbl.push_back(vec(3'b010, {I,N,I}, {SG,SG,SG}, 3'b000, 1, 3'b010, 3'b010, 1, 1, 0));
    tbl.push_back(vec(3'b000, {I,I,I}, {SG,SG,SG}, 3'b000, 1, 3'b000, 3'b000, 1, 0, 0));
    // locked SINGLEs from M1 with M0 requesting
    tbl.push_back(vec(3'b010, {I,N,I}, {SG,SG,SG}, 3'b010, 1, 3'b010, 3'b000, 1, 1, 0));
    tbl.push_back(vec(3'b011, {I,N,N}, {SG,SG,SG}, 3'b010, 1, 3'b010, 3'b010, 1, 1, 0));
    tbl.push_back(vec(3'b011, {I,N,N}, {SG,SG,SG}, 3'b010, 1, 3'b010, 3'b010, 1, 1, 0));
    tbl.push_back(vec(3'b011, {I,N,N}, {SG,SG,SG}, 3'b000, 1, 3'b001, 3'b010, 0, 1, 0));
    tbl.push_back(vec(3'b001, {I,I,N}, {SG,SG,SG}, 3'b000, 1, 3'b001, 3'b001, 0, 1, 0));
    tbl.push_back(vec(3'b000, {I,I,I}, {SG,SG,SG}, 3'b000, 1, 3'b000, 3'b000, 0, 0, 0));
    // undefined INCR with a BUSY beat
    tbl.push_back(vec(3'b001, {I,I,N}, {SG,SG,IC}, 3'b000, 1, 3'b001, 3'b000, 0, 1, 0));
    tbl.push_back(vec(3'b011, {I,N,N}, {SG,SG,IC}, 3'b000, 1, 3'b001, 3'b001, 0, 1, 0));
    tbl.push_back(vec(3'b011, {I,N,S}, {SG,SG,IC}, 3'b000, 1, 3'b001, 3'b001, 0, 1, 0));
    tbl.push_back(vec(3'b010, {I,N,B}, {SG,SG,IC}, 3'b000, 1, 3'b001, 3'b000, 0, 1, 0));
    tbl.push_back(vec(3'b011, {I,N,S}, {SG,SG,IC}, 3'b000, 1, 3'b001, 3'b001, 0, 1, 0));
    tbl.push_back(vec(3'b010, {I,N,I}, {SG,SG,IC}, 3'b000, 1, 3'b010, 3'b000, 1, 1, 0));
    tbl.push_back(vec(3'b010, {I,N,I}, {SG,SG,SG}, 3'b000, 1, 3'b010, 3'b010, 1, 1, 0));
    tbl.push_back(vec(3'b000, {I,I,I}, {SG,SG,SG}, 3'b000, 1, 3'b000, 3'b000, 1, 0, 0));
    // INCR8 cut short when M0 drops its request
    tbl.push_back(vec(3'b001, {I,I,N}, {SG,SG,I8}, 3'b000, 1, 3'b001, 3'b000, 0, 1, 0));
    tbl.push_back(vec(3'b011, {I,N,N}, {SG,SG,I8}, 3'b000, 1, 3'b001, 3'b001, 0, 1, 0));
    tbl.push_back(vec(3'b011, {I,N,S}, {SG,SG,I8}, 3'b000, 1, 3'b001, 3'b001, 0, 1, 0));
    tbl.push_back(vec(3'b010, {I,N,I}, {SG,SG,I8}, 3'b000, 1, 3'b010, 3'b000, 1, 1, 0));
    tbl.push_back(vec(3'b000, {I,I,I}, {SG,SG,SG}, 3'b000, 1, 3'b000, 3'b000, 1, 0, 0));
    run_tbl();
    // async reset in the middle of an INCR8
    tbl.push_back(vec(3'b001, {I,I,N}, {SG,SG,I8}, 3'b000, 1, 3'b001, 3'b000, 0, 1, 0));
    tbl.push_back(vec(3'b001, {I,I,N}, {SG,SG,I8}, 3'b000, 1, 3'b001, 3'b001, 0, 1, 0));
    tbl.push_back(vec(3'b001, {I,I,S}, {SG,SG,I8}, 3'b000, 1, 3'b001, 3'b001, 0, 1, 0));
    tbl.push_back(vec(3'b001, {I,I,S}, {SG,SG,I8}, 3'b000, 1, 3'b001, 3'b001, 0, 1, 0));
    run_tbl();
    #2 rst_n = 1'b0;
    #1 zero_chk("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply(vec(3'b001, {I,I,N}, {SG,SG,SG}, 3'b000, 1, 3'b001, 3'b000, 0, 1, 0));
    // fixed priority instance: M0 beats M1 and can starve it
    tbl.push_back(vec(3'b010, {I,N,I}, {SG,SG,SG}, 3'b000, 1, 3'b010, 3'b000, 1, 1, 1));
    tbl.push_back(vec(3'b011, {I,N,N}, {SG,SG,SG}, 3'b000, 1, 3'b001, 3'b010, 0, 1, 1));
    tbl.push_back(vec(3'b011, {I,N,N}, {SG,SG,SG}, 3'b000, 1, 3'b001, 3'b001, 0, 1, 1));
    tbl.push_back(vec(3'b011, {I,N,N}, {SG,SG,SG}, 3'b000, 1, 3'b001, 3'b001, 0, 1, 1));
    tbl.push_back(vec(3'b010, {I,N,I}, {SG,SG,SG}, 3'b000, 1, 3'b010, 3'b000, 1, 1, 1));
    tbl.push_back(vec(3'b000, {I,I,I}, {SG,SG,SG}, 3'b000, 1, 3'b000, 3'b000, 1, 0, 1));
    run_tbl();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
